// File: rtl/state_seq_pkg.sv
// Shared types and helpers for the state_seq_ctrl motion sequencer.
package state_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_STEP  = 2'd1,
        ST_DWELL = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam int POS_W   = 3;
    localparam int NUM_POS = 8;
    localparam int CNT_W   = 8;

    // Upward distance from cur to tgt, wrapped to a w-bit position space.
    function automatic logic [7:0] up_dist(input logic [7:0] tgt, input logic [7:0] cur,
                                           input int w);
        return (tgt - cur) & ((8'd1 << w) - 8'd1);
    endfunction

endpackage

// File: rtl/state_seq_ctrl_if.sv
// Command handshake and stepper strobes of state_seq_ctrl.
interface state_seq_ctrl_if #(parameter int POS_W = 3);
    logic             cmd_valid;
    logic [POS_W-1:0] cmd_target;
    logic             cmd_ready;
    logic             step;
    logic             dir;
    logic [POS_W-1:0] pos;
    logic             busy;
    logic             done;

    modport master (output cmd_valid, cmd_target,
                    input  cmd_ready, step, dir, pos, busy, done);
    modport slave  (input  cmd_valid, cmd_target,
                    output cmd_ready, step, dir, pos, busy, done);
endinterface

// File: rtl/state_seq_ctrl_dwell_timer.sv
// Loadable down-counter that times the idle gap between steps.
module dwell_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic         zero_o
);
    logic [W-1:0] cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                cnt_q <= '0;
        else if (load_i)        cnt_q <= load_val_i;
        else if (cnt_q != '0)   cnt_q <= cnt_q - 1'b1;
    end

    assign zero_o = (cnt_q == '0);
endmodule

// File: rtl/state_seq_ctrl.sv
// Motion sequencer: walks a tracked position to a commanded target, one step per DWELL+1 cycles.
// Optional macro STATE_SEQ_SHORTEST_PATH_EN enables shortest-path direction; otherwise always up.
module state_seq_ctrl
    import state_seq_pkg::*;
#(
    parameter int DWELL = 4,
    parameter int POS_W = state_seq_pkg::POS_W
) (
    input  logic               clk,
    input  logic               rst,
    state_seq_ctrl_if.slave    bus
);
    localparam logic [CNT_W-1:0] DWELL_LD = CNT_W'(DWELL - 1);

    state_e           state_q;
    logic [POS_W-1:0] pos_q, tgt_q, pos_nx;
    logic             dir_q, dir_d;
    logic             step_q, busy_q, done_q, rdy_q;
    logic             tmr_load, tmr_zero;

`ifdef STATE_SEQ_SHORTEST_PATH_EN
    localparam logic [POS_W-1:0] HALF = {1'b1, {(POS_W-1){1'b0}}};
    logic [POS_W-1:0] up_d;
    assign up_d  = POS_W'(up_dist(8'(bus.cmd_target), 8'(pos_q), POS_W));
    // A tie at exactly half the ring resolves upward.
    assign dir_d = (up_d <= HALF);
`else
    assign dir_d = 1'b1;
`endif

    assign pos_nx   = dir_q ? pos_q + POS_W'(1) : pos_q - POS_W'(1);
    assign tmr_load = (state_q == ST_STEP);

    dwell_timer #(.W(CNT_W)) u_dwell (
        .clk        (clk),
        .rst        (rst),
        .load_i     (tmr_load),
        .load_val_i (DWELL_LD),
        .zero_o     (tmr_zero)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            pos_q   <= '0;
            tgt_q   <= '0;
            dir_q   <= 1'b0;
            step_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            rdy_q   <= 1'b1;
        end else begin
            step_q <= 1'b0;
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: if (bus.cmd_valid && rdy_q) begin
                    tgt_q <= bus.cmd_target;
                    rdy_q <= 1'b0;
                    if (bus.cmd_target == pos_q) begin
                        state_q <= ST_DONE;
                        done_q  <= 1'b1;
                    end else begin
                        state_q <= ST_STEP;
                        step_q  <= 1'b1;
                        busy_q  <= 1'b1;
                        dir_q   <= dir_d;
                    end
                end
                ST_STEP: begin
                    pos_q <= pos_nx;
                    if (pos_nx == tgt_q) begin
                        state_q <= ST_DONE;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                    end else begin
                        state_q <= ST_DWELL;
                    end
                end
                ST_DWELL: if (tmr_zero) begin
                    state_q <= ST_STEP;
                    step_q  <= 1'b1;
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    rdy_q   <= 1'b1;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.cmd_ready = rdy_q;
    assign bus.step      = step_q;
    assign bus.dir       = dir_q;
    assign bus.pos       = pos_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
endmodule

// File: tb/tb_state_seq_ctrl.sv
// Directed bench for state_seq_ctrl with a timeline model derived from the step/done schedule.
module tb_state_seq_ctrl;
    localparam int DW = 2;
    localparam int PW = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    state_seq_ctrl_if #(.POS_W(PW)) bus();
    state_seq_ctrl #(.DWELL(DW), .POS_W(PW)) dut (.clk(clk), .rst(rst), .bus(bus));

    int total = 0;
    int bad   = 0;

    // Model: per command, outputs follow from the handshake-relative cycle number.
    logic m_active = 1'b0;
    int   m_rel    = 0;
    int   m_n      = 0;
    logic m_up     = 1'b0;
    int   m_pos    = 0;
    int   m_tgt    = 0;
    logic m_dir    = 1'b0;

    function automatic int wrap8(input int v);
        return ((v % 8) + 8) % 8;
    endfunction

    function automatic int nsteps(input int tgt, input int cur);
`ifdef STATE_SEQ_SHORTEST_PATH_EN
        int d = wrap8(tgt - cur);
        return (d <= 4) ? d : 8 - d;
`else
        return wrap8(tgt - cur);
`endif
    endfunction

    function automatic logic goes_up(input int tgt, input int cur);
`ifdef STATE_SEQ_SHORTEST_PATH_EN
        return wrap8(tgt - cur) <= 4;
`else
        return 1'b1;
`endif
    endfunction

    function automatic int done_t(input int n);
        return (n == 0) ? 1 : 2 + (n - 1) * (DW + 1);
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_active <= 1'b0; m_rel <= 0; m_n <= 0; m_up <= 1'b0;
            m_pos <= 0; m_tgt <= 0; m_dir <= 1'b0;
        end else if (!m_active) begin
            if (bus.cmd_valid) begin
                m_active <= 1'b1;
                m_rel    <= 1;
                m_tgt    <= int'(bus.cmd_target);
                m_n      <= nsteps(int'(bus.cmd_target), m_pos);
                m_up     <= goes_up(int'(bus.cmd_target), m_pos);
                if (nsteps(int'(bus.cmd_target), m_pos) != 0)
                    m_dir <= goes_up(int'(bus.cmd_target), m_pos);
            end
        end else if (m_rel == done_t(m_n)) begin
            m_active <= 1'b0;
            m_pos    <= m_tgt;
        end else begin
            m_rel <= m_rel + 1;
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    // Per-command measurements taken from the DUT outputs.
    int log_steps[$];
    int busy_cnt = 0;
    int done_rel = -1;
    int n_cmds   = 0;

    initial forever begin
        @(negedge clk);
        if (!rst) begin
            int   cnt;
            int   e_pos;
            logic e_step, e_busy, e_done;
            cnt = 0;
            for (int k = 0; k < m_n; k++)
                if (m_active && (1 + k * (DW + 1) < m_rel)) cnt++;
            e_step = m_active && m_n > 0 && ((m_rel - 1) % (DW + 1)) == 0 &&
                     ((m_rel - 1) / (DW + 1)) < m_n;
            e_busy = m_active && m_n > 0 && m_rel <= 1 + (m_n - 1) * (DW + 1);
            e_done = m_active && m_rel == done_t(m_n);
            e_pos  = m_active ? wrap8(m_pos + (m_up ? cnt : -cnt)) : m_pos;
            chk("cyc ready", int'(bus.cmd_ready), int'(!m_active));
            chk("cyc step",  int'(bus.step), int'(e_step));
            chk("cyc busy",  int'(bus.busy), int'(e_busy));
            chk("cyc done",  int'(bus.done), int'(e_done));
            chk("cyc pos",   int'(bus.pos),  e_pos);
            chk("cyc dir",   int'(bus.dir),  int'(m_dir));
            if (m_active && m_rel == 1) begin
                log_steps.delete();
                busy_cnt = 0;
                done_rel = -1;
                n_cmds++;
            end
            if (bus.step) log_steps.push_back(m_rel);
            if (bus.busy) busy_cnt++;
            if (bus.done) done_rel = m_rel;
        end
    end

    task automatic wait_done(input string nm);
        int i;
        for (i = 0; i < 100; i++) begin
            if (bus.done) break;
            @(negedge clk);
        end
        total++;
        if (i == 100) begin
            bad++;
            $display("FAIL %s timeout: done not seen within 100 cycles", nm);
        end
        #1;
    endtask

    task automatic send(input int tgt, input string nm);
        int i;
        @(negedge clk);
        bus.cmd_valid  = 1'b1;
        bus.cmd_target = 3'(tgt);
        for (i = 0; i < 100; i++) begin
            if (bus.cmd_ready) break;
            @(negedge clk);
        end
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        wait_done(nm);
    endtask

    function automatic int last_step();
        return (log_steps.size() == 0) ? -1 : log_steps[log_steps.size() - 1];
    endfunction

    initial begin
        int s;
        int n0;
        bus.cmd_valid  = 1'b0;
        bus.cmd_target = '0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst ready", int'(bus.cmd_ready), 1);
        chk("rst step",  int'(bus.step), 0);
        chk("rst busy",  int'(bus.busy), 0);
        chk("rst done",  int'(bus.done), 0);
        chk("rst pos",   int'(bus.pos), 0);
        chk("rst dir",   int'(bus.dir), 0);
        #2 rst = 1'b0;

        // 1: reset mid-motion truncates the move immediately
        @(negedge clk);
        bus.cmd_valid = 1'b1; bus.cmd_target = 3'd3;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        s = 0;
        for (int i = 0; i < 50; i++) begin
            if (bus.step) s++;
            if (s == 2) break;
            @(negedge clk);
        end
        chk("t1 two steps seen", s, 2);
        @(negedge clk);
        chk("t1 pos before rst", int'(bus.pos), 2);
        chk("t1 busy before rst", int'(bus.busy), 1);
        #2 rst = 1'b1;
        #1;
        chk("t1 async pos",   int'(bus.pos), 0);
        chk("t1 async busy",  int'(bus.busy), 0);
        chk("t1 async ready", int'(bus.cmd_ready), 1);
        chk("t1 async step",  int'(bus.step), 0);
        @(negedge clk);
        #2 rst = 1'b0;

        // 2: 0 -> 3 upward
        send(3, "t2");
        chk("t2 steps", log_steps.size(), 3);
        chk("t2 first step", (log_steps.size() > 0) ? log_steps[0] : -1, 1);
        chk("t2 last step", last_step(), 7);
        chk("t2 done cyc", done_rel, 8);
        chk("t2 busy cycles", busy_cnt, 7);
        chk("t2 pos", int'(bus.pos), 3);
        chk("t2 dir", int'(bus.dir), 1);

        // 3: 3 -> 1
        send(1, "t3");
`ifdef STATE_SEQ_SHORTEST_PATH_EN
        chk("t3 steps", log_steps.size(), 2);
        chk("t3 done cyc", done_rel, 5);
        chk("t3 dir", int'(bus.dir), 0);
`else
        chk("t3 steps", log_steps.size(), 6);
        chk("t3 done cyc", done_rel, 17);
        chk("t3 dir", int'(bus.dir), 1);
`endif
        chk("t3 pos", int'(bus.pos), 1);

        send(0, "t3 home");
        chk("home pos", int'(bus.pos), 0);

        // 4: tie at 4 resolves up; held valid with new target waits for ready
        n0 = n_cmds;
        @(negedge clk);
        bus.cmd_valid = 1'b1; bus.cmd_target = 3'd4;
        @(negedge clk);
        bus.cmd_target = 3'd6;
        wait_done("t4a");
        chk("t4a steps", log_steps.size(), 4);
        chk("t4a done cyc", done_rel, 11);
        chk("t4a dir", int'(bus.dir), 1);
        chk("t4a pos", int'(bus.pos), 4);
        chk("t4a cmds", n_cmds - n0, 1);
        s = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.step) begin s = 1; break; end
        end
        bus.cmd_valid = 1'b0;
        chk("t4b started", s, 1);
        wait_done("t4b");
        chk("t4b steps", log_steps.size(), 2);
        chk("t4b done cyc", done_rel, 5);
        chk("t4b dir", int'(bus.dir), 1);
        chk("t4b pos", int'(bus.pos), 6);
        chk("t4 cmds", n_cmds - n0, 2);

        // 5: null command at 7, then wrap 7 -> 0
        send(7, "t5 setup");
        chk("t5 setup pos", int'(bus.pos), 7);
        send(7, "t5a");
        chk("t5a steps", log_steps.size(), 0);
        chk("t5a done cyc", done_rel, 1);
        chk("t5a busy cycles", busy_cnt, 0);
        chk("t5a pos", int'(bus.pos), 7);
        send(0, "t5b");
        chk("t5b steps", log_steps.size(), 1);
        chk("t5b done cyc", done_rel, 2);
        chk("t5b dir", int'(bus.dir), 1);
        chk("t5b pos", int'(bus.pos), 0);

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end
endmodule
